execute_sequencer: RTL

- Multi-cycle control FSM that sequences the register-file/ALU datapath for one RV32I instruction at a time.
- Accepts a fetched instruction over a valid/ready handshake and decodes it.
- Drives register addresses and ALU control, waits for the ALU, optionally performs a data-memory load, then issues the register writeback or branch resolution.
- Sits between instruction fetch and the register_ALU datapath.

---
 rtl/execute_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/execute_sequencer.sv
// rtl/execute_sequencer.sv - multi-cycle RV32I execute sequencer driving the register/ALU datapath
module execute_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        alu_source,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] immediate,
    input  logic [31:0] alu_result,
    input  logic        branch,
    output logic        write_enable,
    output logic [31:0] write_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        pc_update,
    output logic        branch_taken,
    output logic        illegal,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_R   = 3'd0,
        K_I   = 3'd1,
        K_B   = 3'd2,
        K_LW  = 3'd3,
        K_BAD = 3'd4
    } kind_t;

    state_t     state;
    kind_t      kind;
    logic [7:0] mem_cnt;

    kind_t       d_kind;
    logic        d_src;
    logic [6:0]  d_opcode;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [31:0] d_imm;

    // Decode feeds only the acceptance registers, so every output stays registered.
    always_comb begin
        d_kind   = K_BAD;
        d_src    = 1'b0;
        d_opcode = instr[6:0];
        d_funct3 = instr[14:12];
        d_funct7 = 7'd0;
        d_imm    = 32'd0;
        case (instr[6:0])
            7'b0110011: begin
                d_kind   = K_R;
                d_funct7 = instr[31:25];
            end
            7'b0010011: begin
                d_kind = K_I;
                d_src  = 1'b1;
                d_imm  = {{20{instr[31]}}, instr[31:20]};
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                    d_funct7 = instr[31:25];
            end
            7'b1100011: begin
                d_kind = K_B;
                d_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0000011: begin
                if (instr[14:12] == 3'b010) begin
                    d_kind   = K_LW;
                    d_src    = 1'b1;
                    d_opcode = 7'b0010011;
                    d_funct3 = 3'b000;
                    d_imm    = {{20{instr[31]}}, instr[31:20]};
                end
            end
            default: d_kind = K_BAD;
        endcase
    end

    assign instr_ready = (state == S_IDLE) && !rst;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            kind         <= K_BAD;
            mem_cnt      <= 8'd0;
            rs1          <= 5'd0;
            rs2          <= 5'd0;
            rd           <= 5'd0;
            alu_source   <= 1'b0;
            opcode       <= 7'd0;
            funct3       <= 3'd0;
            funct7       <= 7'd0;
            immediate    <= 32'd0;
            write_enable <= 1'b0;
            write_data   <= 32'd0;
            mem_req      <= 1'b0;
            mem_addr     <= 32'd0;
            pc_update    <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        rs1        <= instr[19:15];
                        rs2        <= instr[24:20];
                        rd         <= instr[11:7];
                        kind       <= d_kind;
                        alu_source <= d_src;
                        opcode     <= d_opcode;
                        funct3     <= d_funct3;
                        funct7     <= d_funct7;
                        immediate  <= d_imm;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (kind == K_BAD) begin
                        illegal <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (kind)
                        K_R, K_I: begin
                            write_data   <= alu_result;
                            write_enable <= (rd != 5'd0);
                            state        <= S_WB;
                        end
                        K_B: begin
                            pc_update    <= 1'b1;
                            branch_taken <= branch;
                            state        <= S_BR;
                        end
                        K_LW: begin
                            mem_addr <= alu_result;
                            mem_req  <= 1'b1;
                            mem_cnt  <= 8'd0;
                            state    <= S_MEM;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    // Ack is checked first so an ack on the last permitted cycle still completes.
                    if (mem_ack) begin
                        write_data   <= mem_rdata;
                        write_enable <= (rd != 5'd0);
                        mem_req      <= 1'b0;
                        state        <= S_WB;
                    end else if (mem_cnt == 8'(MEM_TIMEOUT - 1)) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        mem_cnt     <= 8'd0;
                        state       <= S_IDLE;
                    end else begin
                        mem_cnt <= mem_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    write_enable <= 1'b0;
                    state        <= S_IDLE;
                end
                S_BR: begin
                    pc_update    <= 1'b0;
                    branch_taken <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
